// File: rtl/queen_pkg.sv
// Shared constants and types for the eight-queen backtracking engine.
package queen_pkg;
    localparam int N     = 8;
    localparam int IDX_W = 3;

    typedef logic [IDX_W-1:0] row_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        BACKTRACK,
        FOUND,
        EXHAUSTED
    } state_t;
endpackage

// File: rtl/queen_safe_check.sv
// Tests one candidate row against every queen already placed in columns below col.
module queen_safe_check
    import queen_pkg::*;
(
    input  row_t pos [N],
    input  row_t col,
    input  row_t cand,
    output logic safe
);

    logic [3:0] d_row;
    logic [3:0] d_col;

    // Differences are taken at 4 bits so |pos - cand| never wraps.
    always_comb begin
        safe  = 1'b1;
        d_row = 4'd0;
        d_col = 4'd0;
        for (int c = 0; c < N; c++) begin
            if (4'(c) < {1'b0, col}) begin
                d_row = (pos[c] > cand) ? ({1'b0, pos[c]} - {1'b0, cand})
                                        : ({1'b0, cand} - {1'b0, pos[c]});
                d_col = {1'b0, col} - 4'(c);
                if ((pos[c] == cand) || (d_row == d_col)) begin
                    safe = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/queen_placer.sv
// Eight-queen backtracking search: streams accepted placements, holds and enumerates solutions.
//   state     | meaning
//   IDLE      | waiting for start
//   CHECK     | testing candidate row cand for column col
//   BACKTRACK | advancing column col past its current row, or retreating further
//   FOUND     | full board held in positions
//   EXHAUSTED | all solutions enumerated
module queen_placer
    import queen_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                next_sol,
    output logic                place_valid,
    output logic [IDX_W-1:0]    place_col,
    output logic [IDX_W-1:0]    place_row,
    output logic [N*IDX_W-1:0]  positions,
    output logic                solution_valid,
    output logic                exhausted,
    output logic                busy,
    output logic [6:0]          sol_count
);

    localparam row_t LAST = row_t'(N - 1);

    state_t     state_q, state_d;
    row_t       col_q, col_d;
    row_t       cand_q, cand_d;
    row_t       pos_q [N];
    row_t       pos_d [N];
    logic [6:0] sol_count_q, sol_count_d;
    logic       place_valid_q, place_valid_d;
    row_t       place_col_q, place_col_d;
    row_t       place_row_q, place_row_d;
    logic       safe;

    queen_safe_check u_safe (
        .pos  (pos_q),
        .col  (col_q),
        .cand (cand_q),
        .safe (safe)
    );

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        cand_d        = cand_q;
        pos_d         = pos_q;
        sol_count_d   = sol_count_q;
        place_valid_d = 1'b0;
        place_col_d   = place_col_q;
        place_row_d   = place_row_q;

        // start outranks next_sol whenever the engine is not busy.
        if (start && (state_q == IDLE || state_q == FOUND || state_q == EXHAUSTED)) begin
            col_d       = '0;
            cand_d      = '0;
            sol_count_d = '0;
            for (int c = 0; c < N; c++) pos_d[c] = '0;
            state_d     = CHECK;
        end else begin
            case (state_q)
                CHECK: begin
                    if (safe) begin
                        pos_d[col_q]  = cand_q;
                        place_valid_d = 1'b1;
                        place_col_d   = col_q;
                        place_row_d   = cand_q;
                        if (col_q == LAST) begin
                            if (sol_count_q != 7'd127) sol_count_d = sol_count_q + 7'd1;
                            state_d = FOUND;
                        end else begin
                            col_d  = col_q + 3'd1;
                            cand_d = '0;
                        end
                    end else if (cand_q != LAST) begin
                        cand_d = cand_q + 3'd1;
                    end else if (col_q == '0) begin
                        state_d = EXHAUSTED;
                    end else begin
                        col_d   = col_q - 3'd1;
                        state_d = BACKTRACK;
                    end
                end
                BACKTRACK: begin
                    if (pos_q[col_q] == LAST) begin
                        if (col_q == '0) state_d = EXHAUSTED;
                        else             col_d   = col_q - 3'd1;
                    end else begin
                        cand_d  = pos_q[col_q] + 3'd1;
                        state_d = CHECK;
                    end
                end
                FOUND: begin
                    if (next_sol) begin
                        col_d   = LAST;
                        state_d = BACKTRACK;
                    end
                end
                IDLE, EXHAUSTED: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            col_q         <= '0;
            cand_q        <= '0;
            sol_count_q   <= '0;
            place_valid_q <= 1'b0;
            place_col_q   <= '0;
            place_row_q   <= '0;
            for (int c = 0; c < N; c++) pos_q[c] <= '0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            cand_q        <= cand_d;
            sol_count_q   <= sol_count_d;
            place_valid_q <= place_valid_d;
            place_col_q   <= place_col_d;
            place_row_q   <= place_row_d;
            pos_q         <= pos_d;
        end
    end

    always_comb begin
        positions = '0;
        for (int c = 0; c < N; c++) positions[IDX_W*c +: IDX_W] = pos_q[c];
    end

    assign place_valid    = place_valid_q;
    assign place_col      = place_col_q;
    assign place_row      = place_row_q;
    assign sol_count      = sol_count_q;
    assign solution_valid = (state_q == FOUND);
    assign exhausted      = (state_q == EXHAUSTED);
    assign busy           = (state_q == CHECK) || (state_q == BACKTRACK);

endmodule

// File: tb/tb_queen_placer.sv
// Directed bench for queen_placer: known solutions, full 92-solution enumeration, restart and reset cases.
module tb_queen_placer;

    localparam logic [23:0] SOL_FIRST  = {3'd3, 3'd1, 3'd6, 3'd2, 3'd5, 3'd7, 3'd4, 3'd0};
    localparam logic [23:0] SOL_SECOND = {3'd4, 3'd1, 3'd3, 3'd6, 3'd2, 3'd7, 3'd5, 3'd0};
    localparam logic [23:0] SOL_LAST   = {3'd4, 3'd6, 3'd1, 3'd5, 3'd2, 3'd0, 3'd3, 3'd7};
    localparam int BOUND = 20000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        next_sol;
    logic        place_valid;
    logic [2:0]  place_col;
    logic [2:0]  place_row;
    logic [23:0] positions;
    logic        solution_valid;
    logic        exhausted;
    logic        busy;
    logic [6:0]  sol_count;

    int n_tests = 0;
    int n_fail  = 0;
    int ref_cycles = 0;

    logic [2:0]  shadow [8];
    int          pulse_cnt = 0;
    int          col7_pulses = 0;
    logic [23:0] seen [$];

    queen_placer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .next_sol       (next_sol),
        .place_valid    (place_valid),
        .place_col      (place_col),
        .place_row      (place_row),
        .positions      (positions),
        .solution_valid (solution_valid),
        .exhausted      (exhausted),
        .busy           (busy),
        .sol_count      (sol_count)
    );

    always #5 clk = ~clk;

    // Downstream stage model: overwrite the row of each column as placements arrive.
    always @(posedge clk) begin
        #1;
        if (place_valid) begin
            shadow[place_col] = place_row;
            pulse_cnt++;
            if (place_col == 3'd7) col7_pulses++;
        end
    end

    function automatic bit board_ok(input logic [23:0] b);
        int ri, rj, d;
        board_ok = 1'b1;
        for (int i = 0; i < 8; i++)
            for (int j = i + 1; j < 8; j++) begin
                ri = int'(b[3*i +: 3]);
                rj = int'(b[3*j +: 3]);
                d  = (ri > rj) ? ri - rj : rj - ri;
                if (ri == rj || d == j - i) board_ok = 1'b0;
            end
    endfunction

    function automatic bit already_seen(input logic [23:0] b);
        already_seen = 1'b0;
        foreach (seen[k]) if (seen[k] == b) already_seen = 1'b1;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_next();
        next_sol = 1'b1;
        @(negedge clk);
        next_sol = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output bit timed_out);
        cycles = 0;
        timed_out = 1'b0;
        while (!solution_valid && !exhausted) begin
            if (cycles >= BOUND) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
        n_tests++;
        if (timed_out) begin
            n_fail++;
            $display("FAIL wait_done: no FOUND/EXHAUSTED after %0d cycles (required < %0d)", cycles, BOUND);
        end
    endtask

    // Checks common to every FOUND: legal board, unseen, encoder bytes cover all rows.
    task automatic check_found(input string tag, input int exp_count);
        logic [7:0] enc_or;
        logic [23:0] sh;
        n_tests++;
        if (solution_valid !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s state: solution_valid=%b busy=%b required 1/0", tag, solution_valid, busy);
        end
        n_tests++;
        if (sol_count !== 7'(exp_count)) begin
            n_fail++;
            $display("FAIL %s sol_count: got %0d required %0d", tag, sol_count, exp_count);
        end
        n_tests++;
        if (!board_ok(positions)) begin
            n_fail++;
            $display("FAIL %s legality: positions=%h shares a row or diagonal", tag, positions);
        end
        n_tests++;
        if (already_seen(positions)) begin
            n_fail++;
            $display("FAIL %s duplicate: positions=%h reported before", tag, positions);
        end
        seen.push_back(positions);
        enc_or = 8'h00;
        for (int c = 0; c < 8; c++) begin
            enc_or  = enc_or | (8'h01 << shadow[c]);
            sh[3*c +: 3] = shadow[c];
        end
        n_tests++;
        if (sh !== positions || enc_or !== 8'hFF) begin
            n_fail++;
            $display("FAIL %s stream: streamed board=%h enc_or=%h required %h / ff", tag, sh, enc_or, positions);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        next_sol = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({place_valid, place_col, place_row, positions, solution_valid, exhausted, busy, sol_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: pv=%b col=%0d row=%0d pos=%h sv=%b ex=%b busy=%b cnt=%0d required all 0",
                     place_valid, place_col, place_row, positions, solution_valid, exhausted, busy, sol_count);
        end
    endtask

    task automatic test_first_solution();
        int cyc;
        bit to;
        pulse_cnt = 0;
        col7_pulses = 0;
        pulse_start();
        n_tests++;
        if (busy !== 1'b1 || sol_count !== 7'd0) begin
            n_fail++;
            $display("FAIL first_busy: busy=%b sol_count=%0d required 1/0", busy, sol_count);
        end
        wait_done(cyc, to);
        ref_cycles = cyc;
        n_tests++;
        if (positions !== SOL_FIRST) begin
            n_fail++;
            $display("FAIL first_positions: got %h required %h", positions, SOL_FIRST);
        end
        n_tests++;
        if (place_valid !== 1'b1 || place_col !== 3'd7 || place_row !== 3'd3) begin
            n_fail++;
            $display("FAIL first_last_place: pv=%b col=%0d row=%0d required 1/7/3", place_valid, place_col, place_row);
        end
        n_tests++;
        if (col7_pulses != 1 || pulse_cnt < 8) begin
            n_fail++;
            $display("FAIL first_pulses: col7=%0d total=%0d required 1 / >=8", col7_pulses, pulse_cnt);
        end
        check_found("first", 1);
        @(negedge clk);
        n_tests++;
        if (place_valid !== 1'b0 || solution_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL found_hold: pv=%b sv=%b required 0/1", place_valid, solution_valid);
        end
    endtask

    task automatic test_start_and_next();
        int cyc;
        bit to;
        start = 1'b1;
        next_sol = 1'b1;
        @(negedge clk);
        start = 1'b0;
        next_sol = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || sol_count !== 7'd0) begin
            n_fail++;
            $display("FAIL both_restart: busy=%b sol_count=%0d required 1/0", busy, sol_count);
        end
        wait_done(cyc, to);
        seen.delete();
        n_tests++;
        if (positions !== SOL_FIRST || cyc != ref_cycles) begin
            n_fail++;
            $display("FAIL both_result: pos=%h cycles=%0d required %h / %0d", positions, cyc, SOL_FIRST, ref_cycles);
        end
        check_found("both", 1);
    endtask

    task automatic test_enumerate_all();
        int cyc;
        bit to;
        for (int k = 2; k <= 92; k++) begin
            pulse_next();
            wait_done(cyc, to);
            if (to) return;
            if (k == 2) begin
                n_tests++;
                if (positions !== SOL_SECOND) begin
                    n_fail++;
                    $display("FAIL second_positions: got %h required %h", positions, SOL_SECOND);
                end
            end
            if (k == 92) begin
                n_tests++;
                if (positions !== SOL_LAST) begin
                    n_fail++;
                    $display("FAIL last_positions: got %h required %h", positions, SOL_LAST);
                end
            end
            check_found($sformatf("sol%0d", k), k);
        end
        pulse_next();
        wait_done(cyc, to);
        n_tests++;
        if (exhausted !== 1'b1 || solution_valid !== 1'b0 || busy !== 1'b0 || sol_count !== 7'd92) begin
            n_fail++;
            $display("FAIL exhausted: ex=%b sv=%b busy=%b cnt=%0d required 1/0/0/92",
                     exhausted, solution_valid, busy, sol_count);
        end
        pulse_next();
        repeat (2) @(negedge clk);
        n_tests++;
        if (exhausted !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL exhausted_next_ignored: ex=%b busy=%b required 1/0", exhausted, busy);
        end
    endtask

    task automatic test_restart_from_exhausted();
        int cyc;
        bit to;
        pulse_start();
        wait_done(cyc, to);
        seen.delete();
        n_tests++;
        if (positions !== SOL_FIRST || cyc != ref_cycles || exhausted !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_exhausted: pos=%h cycles=%0d ex=%b required %h / %0d / 0",
                     positions, cyc, exhausted, SOL_FIRST, ref_cycles);
        end
        check_found("restart", 1);
    endtask

    task automatic test_start_while_busy();
        int cyc;
        bit to;
        pulse_start();
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_before_start: busy=%b required 1", busy);
        end
        pulse_start();
        wait_done(cyc, to);
        seen.delete();
        n_tests++;
        if (positions !== SOL_FIRST || cyc + 4 != ref_cycles) begin
            n_fail++;
            $display("FAIL start_while_busy: pos=%h cycles=%0d required %h / %0d",
                     positions, cyc + 4, SOL_FIRST, ref_cycles);
        end
        check_found("busy_start", 1);
    endtask

    task automatic test_reset_mid_search();
        int cyc;
        bit to;
        pulse_start();
        repeat (49) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_before_rst: busy=%b required 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if ({place_valid, place_col, place_row, positions, solution_valid, exhausted, busy, sol_count} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_values: pv=%b col=%0d row=%0d pos=%h sv=%b ex=%b busy=%b cnt=%0d required all 0",
                     place_valid, place_col, place_row, positions, solution_valid, exhausted, busy, sol_count);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || solution_valid !== 1'b0 || place_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_idle: busy=%b sv=%b pv=%b required 0/0/0", busy, solution_valid, place_valid);
        end
        pulse_start();
        wait_done(cyc, to);
        seen.delete();
        n_tests++;
        if (positions !== SOL_FIRST || cyc != ref_cycles) begin
            n_fail++;
            $display("FAIL mid_reset_rerun: pos=%h cycles=%0d required %h / %0d", positions, cyc, SOL_FIRST, ref_cycles);
        end
        check_found("after_rst", 1);
    endtask

    initial begin
        for (int c = 0; c < 8; c++) shadow[c] = 3'd0;
        rst = 1'b1;
        start = 1'b0;
        next_sol = 1'b0;
        test_reset();
        test_first_solution();
        test_start_and_next();
        test_enumerate_all();
        test_restart_from_exhausted();
        test_start_while_busy();
        test_reset_mid_search();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
